// File: rtl/rf_wb_scheduler_if.sv
// Bus bundle between decode/execute units and the write-back scheduler.
// The master drives issue, write-back and query inputs; the slave is the scheduler.
interface rf_wb_scheduler_if #(
   parameter int N_REQ    = 3,
   parameter int XLEN     = 32,
   parameter int NUM_REGS = 16
);
   logic                    issue_valid;
   logic [4:0]              issue_rd;
   logic                    issue_ready;
   logic [N_REQ-1:0]        wb_valid;
   logic [N_REQ-1:0]        wb_ready;
   logic [5*N_REQ-1:0]      wb_rd;
   logic [XLEN*N_REQ-1:0]   wb_data;
   logic [4:0]              rs1;
   logic [4:0]              rs2;
   logic                    rs1_busy;
   logic                    rs2_busy;
   logic                    rf_reg_write;
   logic [4:0]              rf_rd;
   logic [XLEN-1:0]         rf_rd_data;
   logic [NUM_REGS-1:0]     busy_vec;
   logic                    illegal_rd;

   modport master (
      output issue_valid, issue_rd, wb_valid, wb_rd, wb_data, rs1, rs2,
      input  issue_ready, wb_ready, rs1_busy, rs2_busy,
             rf_reg_write, rf_rd, rf_rd_data, busy_vec, illegal_rd
   );

   modport slave (
      input  issue_valid, issue_rd, wb_valid, wb_rd, wb_data, rs1, rs2,
      output issue_ready, wb_ready, rs1_busy, rs2_busy,
             rf_reg_write, rf_rd, rf_rd_data, busy_vec, illegal_rd
   );
endinterface

// File: rtl/rf_wb_scheduler.sv
// Round-robin write-back arbiter for the shared RF write port, plus a
// scoreboard of in-flight destination registers for RAW/WAW stall decisions.
module rf_wb_scheduler #(
   parameter int N_REQ    = 3,
   parameter int NUM_REGS = 16,
   parameter int XLEN     = 32
) (
   input logic           clk,
   input logic           rst,
   rf_wb_scheduler_if.slave bus
);
   localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   logic [NUM_REGS-1:0] busy_q, busy_d;
   logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
   logic                rf_reg_write_q, rf_reg_write_d;
   logic [4:0]          rf_rd_q, rf_rd_d;
   logic [XLEN-1:0]     rf_rd_data_q, rf_rd_data_d;
   logic                illegal_rd_q, illegal_rd_d;

   logic                issue_ready;
   logic                issue_fire;
   logic                grant_valid;
   logic [PTR_W-1:0]    grant_idx;
   logic [4:0]          grant_rd;
   logic [XLEN-1:0]     grant_data;
   logic [N_REQ-1:0]    wb_ready;
   int                  cand;

   // Issue is only refused for an in-range rd that is already pending.
   assign issue_ready = !rst && !(!bus.issue_rd[4] && busy_q[bus.issue_rd[3:0]]);
   assign issue_fire  = bus.issue_valid && issue_ready;

   always_comb begin
      grant_valid = 1'b0;
      grant_idx   = '0;
      grant_rd    = '0;
      grant_data  = '0;
      cand        = 0;
      for (int k = 0; k < N_REQ; k++) begin
         cand = (int'(rr_ptr_q) + k) % N_REQ;
         if (!rst && !grant_valid && bus.wb_valid[cand]) begin
            grant_valid = 1'b1;
            grant_idx   = PTR_W'(cand);
            grant_rd    = bus.wb_rd[cand*5 +: 5];
            grant_data  = bus.wb_data[cand*XLEN +: XLEN];
         end
      end
   end

   always_comb begin
      wb_ready = '0;
      if (grant_valid) begin
         wb_ready[grant_idx] = 1'b1;
      end
   end

   // The clear for the register being written this cycle is applied first so
   // that a set of the same register at this edge takes priority.
   always_comb begin
      busy_d = busy_q;
      if (rf_reg_write_q) begin
         busy_d[rf_rd_q[3:0]] = 1'b0;
      end
      if (issue_fire && !bus.issue_rd[4] && (bus.issue_rd[3:0] != 4'd0)) begin
         busy_d[bus.issue_rd[3:0]] = 1'b1;
      end
      busy_d[0] = 1'b0;
   end

   always_comb begin
      rr_ptr_d       = rr_ptr_q;
      rf_reg_write_d = 1'b0;
      rf_rd_d        = rf_rd_q;
      rf_rd_data_d   = rf_rd_data_q;
      illegal_rd_d   = (issue_fire && bus.issue_rd[4]) || (grant_valid && grant_rd[4]);
      if (grant_valid) begin
         rr_ptr_d = (grant_idx == PTR_W'(N_REQ - 1)) ? '0 : grant_idx + PTR_W'(1);
         if (!grant_rd[4] && (grant_rd[3:0] != 4'd0)) begin
            rf_reg_write_d = 1'b1;
            rf_rd_d        = grant_rd;
            rf_rd_data_d   = grant_data;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         busy_q         <= '0;
         rr_ptr_q       <= '0;
         rf_reg_write_q <= 1'b0;
         rf_rd_q        <= '0;
         rf_rd_data_q   <= '0;
         illegal_rd_q   <= 1'b0;
      end else begin
         busy_q         <= busy_d;
         rr_ptr_q       <= rr_ptr_d;
         rf_reg_write_q <= rf_reg_write_d;
         rf_rd_q        <= rf_rd_d;
         rf_rd_data_q   <= rf_rd_data_d;
         illegal_rd_q   <= illegal_rd_d;
      end
   end

   assign bus.issue_ready  = issue_ready;
   assign bus.wb_ready     = wb_ready;
   assign bus.rs1_busy     = !bus.rs1[4] && busy_q[bus.rs1[3:0]];
   assign bus.rs2_busy     = !bus.rs2[4] && busy_q[bus.rs2[3:0]];
   assign bus.rf_reg_write = rf_reg_write_q;
   assign bus.rf_rd        = rf_rd_q;
   assign bus.rf_rd_data   = rf_rd_data_q;
   assign bus.busy_vec     = busy_q;
   assign bus.illegal_rd   = illegal_rd_q;
endmodule

// File: tb/tb_rf_wb_scheduler.sv
// Table-driven directed vectors followed by random cycles checked against a
// cycle-level scoreboard model of the write-back scheduler.
module tb_rf_wb_scheduler;
   localparam int N_REQ    = 3;
   localparam int XLEN     = 32;
   localparam int NUM_REGS = 16;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   rf_wb_scheduler_if #(.N_REQ(N_REQ), .XLEN(XLEN), .NUM_REGS(NUM_REGS)) bus ();

   rf_wb_scheduler #(.N_REQ(N_REQ), .NUM_REGS(NUM_REGS), .XLEN(XLEN)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      bit        rst;
      bit        iv;
      bit [4:0]  ird;
      bit [2:0]  wv;
      bit [14:0] wrd;
      bit [95:0] wdata;
      bit [4:0]  rs1;
      bit [4:0]  rs2;
      bit        e_ir;
      bit [2:0]  e_wr;
      bit        e_r1;
      bit        e_r2;
      bit        e_we;
      bit [4:0]  e_rd;
      bit [31:0] e_data;
      bit [15:0] e_busy;
      bit        e_ill;
   } vec_t;

   int checks = 0;
   int passed = 0;

   // Reference state: which registers await write-back and what the RF port shows.
   bit [15:0] m_busy;
   int        m_rr;
   bit        m_we;
   bit [4:0]  m_rd;
   bit [31:0] m_data;
   bit        m_ill;

   function automatic vec_t mk(bit r, bit iv, bit [4:0] ird, bit [2:0] wv,
                               bit [4:0] r0, bit [4:0] r1, bit [4:0] r2,
                               bit [31:0] d0, bit [31:0] d1, bit [31:0] d2,
                               bit [4:0] s1, bit [4:0] s2,
                               bit e_ir, bit [2:0] e_wr, bit e_r1, bit e_r2,
                               bit e_we, bit [4:0] e_rd, bit [31:0] e_data,
                               bit [15:0] e_busy, bit e_ill);
      vec_t v;
      v.rst = r; v.iv = iv; v.ird = ird; v.wv = wv;
      v.wrd = {r2, r1, r0}; v.wdata = {d2, d1, d0};
      v.rs1 = s1; v.rs2 = s2;
      v.e_ir = e_ir; v.e_wr = e_wr; v.e_r1 = e_r1; v.e_r2 = e_r2;
      v.e_we = e_we; v.e_rd = e_rd; v.e_data = e_data;
      v.e_busy = e_busy; v.e_ill = e_ill;
      return v;
   endfunction

   function automatic bit pending(bit [4:0] r);
      return (r >= 5'd1 && r <= 5'd15) ? m_busy[r[3:0]] : 1'b0;
   endfunction

   task automatic applyStimulus(input vec_t v);
      rst             = v.rst;
      bus.issue_valid = v.iv;
      bus.issue_rd    = v.ird;
      bus.wb_valid    = v.wv;
      bus.wb_rd       = v.wrd;
      bus.wb_data     = v.wdata;
      bus.rs1         = v.rs1;
      bus.rs2         = v.rs2;
   endtask

   task automatic checkOutput(input string name, input int idx,
                              input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) begin
         passed++;
      end else begin
         $display("[TB] FAIL %s cycle %0d: got %0h expected %0h", name, idx, act, exp);
      end
   endtask

   task automatic modelComb(input vec_t v, output bit ir, output bit [2:0] wr,
                            output bit r1, output bit r2, output int g);
      ir = !v.rst && !pending(v.ird);
      g  = -1;
      wr = '0;
      if (!v.rst) begin
         for (int k = 0; k < N_REQ; k++) begin
            int c;
            c = (m_rr + k) % N_REQ;
            if (g < 0 && v.wv[c]) g = c;
         end
      end
      if (g >= 0) wr[g] = 1'b1;
      r1 = pending(v.rs1);
      r2 = pending(v.rs2);
   endtask

   task automatic modelUpdate(input vec_t v, input int g, input bit ir);
      bit [15:0] nb;
      bit [4:0]  grd;
      bit        gwrite;
      if (v.rst) begin
         m_busy = '0; m_rr = 0; m_we = 0; m_rd = '0; m_data = '0; m_ill = 0;
         return;
      end
      grd    = (g >= 0) ? v.wrd[g*5 +: 5] : 5'd0;
      gwrite = (g >= 0) && grd >= 5'd1 && grd <= 5'd15;
      nb = m_busy;
      if (m_we) nb[m_rd[3:0]] = 1'b0;
      if (v.iv && ir && v.ird >= 5'd1 && v.ird <= 5'd15) nb[v.ird[3:0]] = 1'b1;
      m_ill  = (v.iv && ir && v.ird >= 5'd16) || (g >= 0 && grd >= 5'd16);
      m_busy = nb;
      m_we   = gwrite;
      if (gwrite) begin
         m_rd   = grd;
         m_data = v.wdata[g*32 +: 32];
      end
      if (g >= 0) m_rr = (g + 1) % N_REQ;
   endtask

   task automatic runCycle(input vec_t v, input bit use_table, input int idx);
      bit ir, r1, r2;
      bit [2:0] wr;
      int g;
      applyStimulus(v);
      #4;
      modelComb(v, ir, wr, r1, r2, g);
      checkOutput("issue_ready", idx, 32'(bus.issue_ready), 32'(use_table ? v.e_ir : ir));
      checkOutput("wb_ready",    idx, 32'(bus.wb_ready),    32'(use_table ? v.e_wr : wr));
      checkOutput("rs1_busy",    idx, 32'(bus.rs1_busy),    32'(use_table ? v.e_r1 : r1));
      checkOutput("rs2_busy",    idx, 32'(bus.rs2_busy),    32'(use_table ? v.e_r2 : r2));
      modelUpdate(v, g, ir);
      @(posedge clk);
      #1;
      checkOutput("rf_reg_write", idx, 32'(bus.rf_reg_write), 32'(use_table ? v.e_we : m_we));
      checkOutput("rf_rd",        idx, 32'(bus.rf_rd),        32'(use_table ? v.e_rd : m_rd));
      checkOutput("rf_rd_data",   idx, bus.rf_rd_data,        use_table ? v.e_data : m_data);
      checkOutput("busy_vec",     idx, 32'(bus.busy_vec),     32'(use_table ? v.e_busy : m_busy));
      checkOutput("illegal_rd",   idx, 32'(bus.illegal_rd),   32'(use_table ? v.e_ill : m_ill));
   endtask

   vec_t vecs[$];

   initial begin
      vec_t v;
      // Grant order 0,1,2 repeating, then 0,2 alternating.
      bit [2:0] g111 [6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
      bit [2:0] g101 [4] = '{3'b001, 3'b100, 3'b001, 3'b100};
      bit [4:0]  grd_of [3] = '{5'd8, 5'd9, 5'd10};
      bit [31:0] gdt_of [3] = '{32'hA0, 32'hA1, 32'hA2};

      vecs.push_back(mk(1,1,5, 3'b000, 0,0,0, 0,0,0, 0,0,  0,3'b000,0,0, 0,0,0,16'h0000,0));
      vecs.push_back(mk(0,0,5, 3'b000, 0,0,0, 0,0,0, 5,0,  1,3'b000,0,0, 0,0,0,16'h0000,0));
      vecs.push_back(mk(0,1,5, 3'b000, 0,0,0, 0,0,0, 5,0,  1,3'b000,0,0, 0,0,0,16'h0020,0));
      vecs.push_back(mk(0,1,5, 3'b000, 0,0,0, 0,0,0, 5,0,  0,3'b000,1,0, 0,0,0,16'h0020,0));
      vecs.push_back(mk(0,0,5, 3'b001, 5,0,0, 32'hDEADBEEF,0,0, 5,0,
                        0,3'b001,1,0, 1,5,32'hDEADBEEF,16'h0020,0));
      vecs.push_back(mk(0,0,5, 3'b000, 0,0,0, 0,0,0, 5,0,  0,3'b000,1,0, 0,5,32'hDEADBEEF,16'h0000,0));
      vecs.push_back(mk(0,0,5, 3'b000, 0,0,0, 0,0,0, 5,0,  1,3'b000,0,0, 0,5,32'hDEADBEEF,16'h0000,0));
      vecs.push_back(mk(0,0,0, 3'b100, 0,0,0, 0,0,32'h1234, 0,0,
                        1,3'b100,0,0, 0,5,32'hDEADBEEF,16'h0000,0));
      for (int i = 0; i < 6; i++) begin
         vecs.push_back(mk(0,0,0, 3'b111, 8,9,10, 32'hA0,32'hA1,32'hA2, 0,0,
                           1,g111[i],0,0, 1,grd_of[i%3],gdt_of[i%3],16'h0000,0));
      end
      for (int i = 0; i < 4; i++) begin
         vecs.push_back(mk(0,0,0, 3'b101, 8,9,10, 32'hA0,32'hA1,32'hA2, 0,0,
                           1,g101[i],0,0, 1,grd_of[(i%2)*2],gdt_of[(i%2)*2],16'h0000,0));
      end
      vecs.push_back(mk(0,1,17, 3'b000, 0,0,0, 0,0,0, 0,0, 1,3'b000,0,0, 0,10,32'hA2,16'h0000,1));
      vecs.push_back(mk(0,0,17, 3'b000, 0,0,0, 0,0,0, 0,0, 1,3'b000,0,0, 0,10,32'hA2,16'h0000,0));
      vecs.push_back(mk(0,1,3,  3'b000, 0,0,0, 0,0,0, 0,0, 1,3'b000,0,0, 0,10,32'hA2,16'h0008,0));
      vecs.push_back(mk(0,1,7,  3'b000, 0,0,0, 0,0,0, 0,3, 1,3'b000,0,1, 0,10,32'hA2,16'h0088,0));
      vecs.push_back(mk(0,0,7,  3'b010, 0,3,0, 0,32'h55,0, 3,0,
                        0,3'b010,1,0, 1,3,32'h55,16'h0088,0));
      vecs.push_back(mk(1,0,7,  3'b010, 0,3,0, 0,32'h55,0, 3,0,
                        0,3'b000,1,0, 0,0,0,16'h0000,0));
      vecs.push_back(mk(0,0,7,  3'b000, 0,0,0, 0,0,0, 7,3, 1,3'b000,0,0, 0,0,0,16'h0000,0));

      // Unchecked power-on reset so the scoreboard starts from a known state.
      v = mk(1,0,0, 3'b000, 0,0,0, 0,0,0, 0,0, 0,0,0,0, 0,0,0,0,0);
      applyStimulus(v);
      @(posedge clk);
      #1;
      m_busy = '0; m_rr = 0; m_we = 0; m_rd = '0; m_data = '0; m_ill = 0;

      for (int i = 0; i < vecs.size(); i++) begin
         runCycle(vecs[i], 1'b1, i);
      end

      runCycle(v, 1'b0, 1000);
      for (int i = 0; i < 400; i++) begin
         vec_t r;
         r = v;
         r.rst   = ($urandom_range(0, 59) == 0);
         r.iv    = $urandom_range(0, 1) != 0;
         r.ird   = 5'($urandom_range(0, 19));
         r.wv    = 3'($urandom_range(0, 7));
         r.wrd   = {5'($urandom_range(0, 19)), 5'($urandom_range(0, 19)), 5'($urandom_range(0, 19))};
         r.wdata = {32'($urandom), 32'($urandom), 32'($urandom)};
         r.rs1   = 5'($urandom_range(0, 19));
         r.rs2   = 5'($urandom_range(0, 19));
         runCycle(r, 1'b0, 2000 + i);
      end

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule

// File: doc/rf_wb_scheduler.md
Name: rf_wb_scheduler

Overview:
Write-back scheduler and scoreboard for the RV32E 16-entry register file. Shares the single RF write port between N_REQ write-back requesters (0=ALU, 1=LSU, 2=MUL/DIV) with round-robin arbitration. Tracks in-flight destination registers so decode can stall on RAW and WAW hazards. Sits between the execute units and the RF write port; decode drives the issue and query ports.

Parameters:
N_REQ, 3, number of write-back requesters
NUM_REGS, 16, architectural registers (RV32E)
XLEN, 32, data width

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous active-high reset
issue_valid  in  1  decode issuing an instruction with a destination
issue_rd  in  5  destination of issuing instruction
issue_ready  out  1  issue accepted this cycle
wb_valid  in  N_REQ  per-requester write-back request
wb_ready  out  N_REQ  per-requester grant (one-hot or zero)
wb_rd  in  5*N_REQ  packed destination, requester i at [5i+4:5i]
wb_data  in  XLEN*N_REQ  packed result, requester i at [XLEN*i+XLEN-1:XLEN*i]
rs1  in  5  hazard query source 1
rs2  in  5  hazard query source 2
rs1_busy  out  1  rs1 has a pending write
rs2_busy  out  1  rs2 has a pending write
rf_reg_write  out  1  RF write enable
rf_rd  out  5  RF write address
rf_rd_data  out  XLEN  RF write data
busy_vec  out  NUM_REGS  scoreboard state, bit i = x_i pending
illegal_rd  out  1  one-cycle pulse: rd[4]=1 seen on an accepted issue or grant

Behaviour:
- Reset (sync, rst=1 at rising edge): busy_vec=0, rr_ptr=0, rf_reg_write=0, rf_rd=0, rf_rd_data=0, illegal_rd=0. A grant and an issue in the reset cycle are discarded. wb_ready and issue_ready are forced 0 while rst=1.
- Scoreboard state: busy[15:0] plus rr_ptr (clog2(N_REQ) bits). busy[0] is constantly 0.
- Issue:
  - issue_ready = !rst && !(issue_rd[4]==0 && busy[issue_rd[3:0]]), combinational from registered busy only. No same-cycle release.
  - On issue_valid && issue_ready with rd in 1..15: busy[rd] is set at the next edge.
  - rd=0: accepted, with no busy change.
  - rd>=16: accepted, with no busy change. illegal_rd pulses next cycle.
- Arbitration (cycle N):
  - Search wb_valid starting at rr_ptr, wrapping modulo N_REQ. The first valid requester g gets wb_ready[g]=1 (combinational).
  - Handshake completes in the same cycle, and the requester drops or advances its data.
  - At most one grant per cycle.
  - rr_ptr <= (g+1) mod N_REQ on grant. rr_ptr is unchanged when there is no request.
- Write port (cycle N+1, registered):
  - rf_reg_write=1 iff granted rd in 1..15.
  - rf_rd and rf_rd_data are the granted values.
  - When there is no grant, or rd=0: rf_reg_write=0 and rf_rd/rf_rd_data hold their previous values.
  - Granted rd>=16: consumed, no write, illegal_rd pulses in N+1.
- Busy clear:
  - busy[rf_rd] is cleared at the edge ending N+1 (the same edge on which the RF captures the data).
  - A query in N+2 therefore sees busy=0 and reads the updated RF. Latency from grant to visible RF data is 2 cycles.
- Queries:
  - rsX_busy = (rsX[4]==0) && busy[rsX[3:0]], combinational.
  - rs=0 always returns 0.
  - No bypass: a register is reported busy during its write-back cycle N+1.
- Simultaneous set and clear of the same register at one edge cannot occur, because issue_ready blocks issue to a busy register. If it ever arises, set wins.
- A write-back to a non-busy register (no matching issue) is still written and does not disturb other bits.
- Reset mid-operation: pending busy bits and any registered write are dropped. rf_reg_write is 0 on the cycle after rst.

Test Plan:
- Reset → busy_vec=0, rf_reg_write=0, issue_ready=1 for issue_rd=5, wb_ready=000 with wb_valid=000.
- Issue rd=5, then query rs1=5 → rs1_busy=1. A second issue of rd=5 gets issue_ready=0. ALU wb rd=5 data=0xDEADBEEF in cycle N → rf_reg_write=1, rf_rd=5, rf_rd_data=0xDEADBEEF in N+1, rs1_busy=0 in N+2.
- Hold wb_valid=111 for 6 cycles with rr_ptr=0 → grants 0,1,2,0,1,2. With wb_valid=101 → grants alternate 0,2.
- wb rd=0 data=0x1234 → wb_ready=1, rf_reg_write=0, busy_vec unchanged. Query rs2=0 → rs2_busy=0.
- Issue rd=17 → accepted, illegal_rd=1 for exactly one cycle, busy_vec unchanged.
- Issue rd=3 and rd=7, then assert rst for one cycle while LSU wb rd=3 is granted → busy_vec=0 and rf_reg_write=0 the cycle after reset.
